// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// Slave side is the controller, master side is the operand source/result sink.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_valid;
  logic             i_ack;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic             o_busy;

  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_ack,
    output o_ready, o_valid, o_sum, o_cout, o_ovf, o_busy
  );

  modport master (
    output i_valid, i_a, i_b, i_cin, i_ack,
    input  o_ready, o_valid, o_sum, o_cout, o_ovf, o_busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder stage reused for WIDTH cycles, LSB first.
// Result registers only update on the last bit, so outputs hold between ops.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic          i_clk,
  input logic          i_rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] sh_nxt;

  // Single full-adder stage plus the shift-in of its sum bit at the MSB.
  always_comb begin
    s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
    c_bit  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    sh_nxt = (sh_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  end

  // Next-state and datapath updates for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          carry_d = bus.i_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = sh_nxt;
        carry_d = c_bit;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = sh_nxt;
          cout_d  = c_bit;
          ovf_d   = carry_q ^ c_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status and result outputs decoded from state and result registers.
  always_comb begin
    bus.o_ready = (state_q == IDLE);
    bus.o_busy  = (state_q == RUN);
    bus.o_valid = (state_q == DONE);
    bus.o_sum   = sum_q;
    bus.o_cout  = cout_q;
    bus.o_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH 8, 1 and 16 instances, directed
// steps then a random sweep, with a queue of expected results.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int widths [3] = '{8, 1, 16};

  logic        v    [3];
  logic        ack  [3];
  logic        cin  [3];
  logic [31:0] a    [3];
  logic [31:0] b    [3];
  logic        rdy  [3];
  logic        vld  [3];
  logic        cout [3];
  logic        ovf  [3];
  logic        busy [3];
  logic [31:0] sum  [3];

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] last_sum;

  serial_adder_if #(.WIDTH(8))  bus0 ();
  serial_adder_if #(.WIDTH(1))  bus1 ();
  serial_adder_if #(.WIDTH(16)) bus2 ();

  serial_adder_ctrl #(.WIDTH(8)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));
  serial_adder_ctrl #(.WIDTH(16)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus2.slave));

  assign bus0.i_valid = v[0];
  assign bus0.i_ack   = ack[0];
  assign bus0.i_cin   = cin[0];
  assign bus0.i_a     = a[0][7:0];
  assign bus0.i_b     = b[0][7:0];
  assign rdy[0]  = bus0.o_ready;
  assign vld[0]  = bus0.o_valid;
  assign cout[0] = bus0.o_cout;
  assign ovf[0]  = bus0.o_ovf;
  assign busy[0] = bus0.o_busy;
  assign sum[0]  = 32'(bus0.o_sum);

  assign bus1.i_valid = v[1];
  assign bus1.i_ack   = ack[1];
  assign bus1.i_cin   = cin[1];
  assign bus1.i_a     = a[1][0:0];
  assign bus1.i_b     = b[1][0:0];
  assign rdy[1]  = bus1.o_ready;
  assign vld[1]  = bus1.o_valid;
  assign cout[1] = bus1.o_cout;
  assign ovf[1]  = bus1.o_ovf;
  assign busy[1] = bus1.o_busy;
  assign sum[1]  = 32'(bus1.o_sum);

  assign bus2.i_valid = v[2];
  assign bus2.i_ack   = ack[2];
  assign bus2.i_cin   = cin[2];
  assign bus2.i_a     = a[2][15:0];
  assign bus2.i_b     = b[2][15:0];
  assign rdy[2]  = bus2.o_ready;
  assign vld[2]  = bus2.o_valid;
  assign cout[2] = bus2.o_cout;
  assign ovf[2]  = bus2.o_ovf;
  assign busy[2] = bus2.o_busy;
  assign sum[2]  = 32'(bus2.o_sum);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(int w, logic [31:0] x, logic [31:0] y,
                                 logic c);
    exp_t        r;
    logic [32:0] full;
    logic [31:0] m;
    logic        sa, sbb, ss;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    x    = x & m;
    y    = y & m;
    full = {1'b0, x} + {1'b0, y} + {32'd0, c};
    r.sum  = full[31:0] & m;
    r.cout = full[w];
    sa  = x[w-1];
    sbb = y[w-1];
    ss  = r.sum[w-1];
    r.ovf = (sa == sbb) && (ss != sa);
    return r;
  endfunction

  task automatic start(int k, logic [31:0] x, logic [31:0] y, logic c,
                       logic hold);
    int g;
    g = 0;
    @(negedge clk);
    v[k]   = 1'b1;
    a[k]   = x;
    b[k]   = y;
    cin[k] = c;
    while (!rdy[k] && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", rdy[k], 1);
    sb.push_back(model(widths[k], x, y, c));
    @(posedge clk);
    #1;
    if (!hold) v[k] = 1'b0;
  endtask

  task automatic wait_result(int k);
    int   lat;
    exp_t e;
    lat = 1;
    @(negedge clk);
    chk("busy_run", busy[k], 1);
    chk("ready_run", rdy[k], 0);
    while (!vld[k] && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    chk("valid", vld[k], 1);
    chk("latency", lat, widths[k] + 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("sum", sum[k], e.sum);
      chk("cout", cout[k], e.cout);
      chk("ovf", ovf[k], e.ovf);
      last_sum = e.sum;
    end
  endtask

  task automatic ack_res(int k, int d);
    repeat (d) begin
      @(negedge clk);
      chk("hold_valid", vld[k], 1);
      chk("hold_sum", sum[k], last_sum);
    end
    @(negedge clk);
    ack[k] = 1'b1;
    @(posedge clk);
    #1;
    ack[k] = 1'b0;
    chk("ack_drop_valid", vld[k], 0);
    chk("ack_ready", rdy[k], 1);
  endtask

  initial begin
    exp_t junk;
    for (int i = 0; i < 3; i++) begin
      v[i]   = 1'b0;
      ack[i] = 1'b0;
      cin[i] = 1'b0;
      a[i]   = '0;
      b[i]   = '0;
    end
    last_sum = '0;

    #12;
    chk("rst_ready", rdy[0], 1);
    chk("rst_valid", vld[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_sum", sum[0], 0);
    chk("rst_cout", cout[0], 0);
    chk("rst_ovf", ovf[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    start(0, 32'h0F, 32'h01, 1'b0, 1'b0);
    wait_result(0);
    chk("t1_sum_const", sum[0], 32'h10);
    ack_res(0, 0);

    start(0, 32'hFF, 32'h01, 1'b0, 1'b0);
    wait_result(0);
    chk("t2a_cout_const", cout[0], 1);
    ack_res(0, 1);
    start(0, 32'h7F, 32'h01, 1'b0, 1'b0);
    wait_result(0);
    chk("t2b_ovf_const", ovf[0], 1);
    ack_res(0, 2);

    start(0, 32'hFF, 32'hFF, 1'b1, 1'b0);
    wait_result(0);
    ack_res(0, 20);

    start(0, 32'h12, 32'h34, 1'b0, 1'b1);
    a[0] = 32'hAA;
    b[0] = 32'h55;
    wait_result(0);
    chk("t4_first_const", sum[0], 32'h46);
    ack_res(0, 3);
    start(0, 32'hAA, 32'h55, 1'b0, 1'b0);
    wait_result(0);
    chk("t4_second_const", sum[0], 32'hFF);
    ack_res(0, 0);

    start(0, 32'h11, 32'h22, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ready", rdy[0], 1);
    chk("t5_valid", vld[0], 0);
    chk("t5_busy", busy[0], 0);
    chk("t5_sum", sum[0], 0);
    junk = sb.pop_back();
    @(negedge clk);
    rst_n = 1'b1;
    start(0, 32'h01, 32'h01, 1'b0, 1'b0);
    wait_result(0);
    ack_res(0, 0);

    for (int i = 0; i < 8; i++) begin
      start(1, 32'(i & 1), 32'((i >> 1) & 1), i[2], 1'b0);
      wait_result(1);
      ack_res(1, 0);
    end

    start(2, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    wait_result(2);
    ack_res(2, 0);

    for (int n = 0; n < 1000; n++) begin
      int k;
      k = $urandom_range(0, 2);
      start(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      wait_result(k);
      ack_res(k, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
